div_unit: RTL
=============

Name: div_unit

Overview:
- Multi-cycle radix-2 divider producing the 64-bit `divres` bus consumed by the execute-stage ALU for DIV/DIVU.
- `divres[63:32]` is the remainder (goes to HI) and `divres[31:0]` is the quotient (goes to LO).
- Sits beside the ALU in EX; holds the pipeline via `div_stall` until the result is ready.

Parameters:
- DATA_W, 32, operand width; `divres` is 2*DATA_W.
- ITERS, DATA_W, number of iteration cycles (one quotient bit per cycle).

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  request to begin a divide; sampled in IDLE only.
- signed_div  in  1  1 = DIV (signed), 0 = DIVU (unsigned); latched at start.
- a  in  DATA_W  dividend; latched at start.
- b  in  DATA_W  divisor; latched at start.
- cancel  in  1  flush from exception/ERET; aborts the current operation.
- div_stall  out  1  combinational; the pipeline must freeze while high.
- div_valid  out  1  `divres` is valid this cycle (one-cycle pulse).
- divres  out  2*DATA_W  {remainder, quotient}, registered.

Behaviour:
- Reset (async, resetn=0): state=IDLE, div_valid=0, divres=0, counter=0, internal registers=0.
- FSM states: IDLE, DIVZERO, ON, DONE.
- IDLE:
  - start=1 and cancel=0 and b!=0 -> ON. Latch |a|, |b|, the sign flags and signed_div; clear the partial remainder; counter=0.
  - start=1 and cancel=0 and b==0 -> DIVZERO.
  - start=1 and cancel=1 -> stay in IDLE (cancel wins).
- ON, one restoring step per cycle:
  - Shift {rem, quo} left by 1.
  - Trial subtract of the divisor from rem; if the result is non-negative, rem=diff and quo[0]=1.
  - counter increments each cycle; when counter==ITERS-1 -> DONE.
- DIVZERO: -> DONE next cycle with divres=0. MIPS leaves this result undefined; we fix it to 0.
- DONE:
  - div_valid=1 for exactly one cycle, then -> IDLE.
  - divres is registered on entry to DONE and holds its value until the next DONE or reset.
- Latency: start sampled at edge T.
  - Normal divide: div_valid high in cycle T+33 (1 + 32 iterations).
  - Divide by zero: div_valid high in cycle T+2.
- div_stall = (state==IDLE & start & ~cancel) | state==ON | state==DIVZERO. It is low in DONE, so the ALU captures `divres` in the DONE cycle and the pipeline advances.
- Sign fix-up, applied when entering DONE if signed_div=1:
  - Quotient is negated if sign(a) ^ sign(b).
  - Remainder is negated if sign(a), so the remainder takes the sign of the dividend.
- Magnitudes are computed unsigned, so 0x80000000 has magnitude 0x80000000.
- Overflow case 0x80000000 / 0xFFFFFFFF (signed) gives quotient 0x80000000 and remainder 0 (wrap, no trap).
- Changes on a, b or signed_div after start are ignored until the next IDLE.
- start while not in IDLE is ignored.
- cancel=1 in ON, DIVZERO or DONE: -> IDLE at the next edge. div_valid stays 0, or drops if cancel arrives in DONE. divres is not updated.
- Reset mid-operation: immediately IDLE; outputs return to their reset values.

Decomposition:
- Shared package div_pkg:
  - State enum {IDLE, DIVZERO, ON, DONE}, 2-bit encoding 00/01/10/11.
  - DATA_W constant.
  - Counter width $clog2(DATA_W).
- One natural sub-module: div_step, a combinational single restoring iteration.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.
  - Instantiated once; the FSM, counter and sign logic stay in div_unit.

Test Plan:
- Unsigned 7/2, start at T: div_stall=1 for T..T+32, div_valid=1 at T+33, divres=0x00000001_00000003, then IDLE.
- Signed -7/2 (a=0xFFFFFFF9, b=2) -> divres=0xFFFFFFFF_FFFFFFFD. Signed 7/-2 -> 0x00000001_FFFFFFFD.
- Signed 0x80000000/0xFFFFFFFF -> divres=0x00000000_80000000. Unsigned 0xFFFFFFFF/1 -> 0x00000000_FFFFFFFF.
- b=0, start at T -> div_valid=1 at T+2, divres=0. Back-to-back start in the cycle after DONE is accepted and a second valid result appears.
- Cancel at T+10 of a divide -> IDLE at T+11, no div_valid pulse, divres unchanged from the prior result. start with cancel in the same IDLE cycle -> no operation.
- resetn low at T+20 mid-divide -> state IDLE, div_valid=0, divres=0 asynchronously. After release, a new 100/7 divide gives 0x00000002_0000000E.

Source files
------------

// File: rtl/div_pkg.sv
// div_pkg: shared width constants and FSM encoding for the divider
package div_pkg;
    localparam int DATA_W = 32;
    localparam int CNT_W  = $clog2(DATA_W);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        DIVZERO = 2'b01,
        ON      = 2'b10,
        DONE    = 2'b11
    } state_e;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring division iteration on a {rem, quo} pair
module div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem_i,
    input  logic [W-1:0] quo_i,
    input  logic [W-1:0] divisor_i,
    output logic [W-1:0] rem_o,
    output logic [W-1:0] quo_o
);
    logic [W:0] sh, diff;
    assign sh    = {rem_i, quo_i[W-1]};
    // rem < divisor always holds, so diff[W] is exactly the borrow of the trial subtract
    assign diff  = sh - {1'b0, divisor_i};
    assign rem_o = diff[W] ? sh[W-1:0] : diff[W-1:0];
    assign quo_o = {quo_i[W-2:0], ~diff[W]};
endmodule

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider returning {remainder, quotient} for DIV/DIVU
module div_unit #(
    parameter int DATA_W = div_pkg::DATA_W,
    parameter int ITERS  = DATA_W
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic                signed_div,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    input  logic                cancel,
    output logic                div_stall,
    output logic                div_valid,
    output logic [2*DATA_W-1:0] divres
);
    import div_pkg::*;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [DATA_W-1:0]   rem_n, quo_n, a_mag, b_mag;
    logic                negq_q, negq_d, negr_q, negr_d;
    logic [2*DATA_W-1:0] divres_q, divres_d;
    logic                go, last;

    assign go    = start & ~cancel;
    assign last  = cnt_q == CNT_W'(ITERS - 1);
    assign a_mag = (signed_div & a[DATA_W-1]) ? -a : a;
    assign b_mag = (signed_div & b[DATA_W-1]) ? -b : b;

    div_step #(.W(DATA_W)) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (dvs_q),
        .rem_o     (rem_n),
        .quo_o     (quo_n)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        divres_d = divres_q;
        case (state_q)
            IDLE: if (go) begin
                state_d = (b == '0) ? DIVZERO : ON;
                cnt_d   = '0;
                rem_d   = '0;
                quo_d   = a_mag;
                dvs_d   = b_mag;
                negq_d  = signed_div & (a[DATA_W-1] ^ b[DATA_W-1]);
                negr_d  = signed_div & a[DATA_W-1];
            end
            ON: if (cancel) state_d = IDLE;
            else begin
                rem_d = rem_n;
                quo_d = quo_n;
                cnt_d = cnt_q + 1'b1;
                if (last) begin
                    state_d  = DONE;
                    divres_d = {negr_q ? -rem_n : rem_n, negq_q ? -quo_n : quo_n};
                end
            end
            DIVZERO: begin
                state_d  = cancel ? IDLE : DONE;
                divres_d = cancel ? divres_q : '0;
            end
            DONE: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            divres_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            divres_q <= divres_d;
        end
    end

    assign div_stall = (state_q == IDLE & go) | state_q == ON | state_q == DIVZERO;
    assign div_valid = state_q == DONE & ~cancel;
    assign divres    = divres_q;
endmodule
